// File: rtl/mux4_scan_ctrl.sv
// Scan sequencer for a 4:1 mux: steps the select over enabled channels and
// dwells on each one. It samples the mux output into a 4-bit frame and pulses frame_valid when the frame is done.
module mux4_scan_ctrl #(
  parameter int DWELL = 2,
  parameter int CW    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cont,
  input  logic       stop,
  input  logic [3:0] mask,
  input  logic       z,
  output logic [1:0] sel,
  output logic       busy,
  output logic [3:0] frame,
  output logic       frame_valid
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t          r_state, w_state;
  logic [1:0]      r_sel, w_sel;
  logic [CW-1:0]   r_cnt, w_cnt;
  logic [3:0]      r_mask, w_mask;
  logic            r_cont, w_cont;
  logic [3:0]      r_acc, w_acc;
  logic [3:0]      r_frame, w_frame;
  logic            r_fv, w_fv;
  logic [3:0]      w_samp;

  function automatic logic [1:0] f_lowest(input logic [3:0] m);
    logic [1:0] res;
    res = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (m[i]) res = 2'(i);
    return res;
  endfunction

  // Lowest enabled channel strictly above cur; cur itself if none.
  function automatic logic [1:0] f_next(input logic [3:0] m, input logic [1:0] cur);
    logic [1:0] res;
    res = cur;
    for (int i = 3; i >= 0; i--)
      if (m[i] && (i > int'(cur))) res = 2'(i);
    return res;
  endfunction

  function automatic logic f_is_last(input logic [3:0] m, input logic [1:0] cur);
    logic res;
    res = 1'b1;
    for (int i = 0; i < 4; i++)
      if (m[i] && (i > int'(cur))) res = 1'b0;
    return res;
  endfunction

  always_comb begin
    w_state = r_state;
    w_sel   = r_sel;
    w_cnt   = r_cnt;
    w_mask  = r_mask;
    w_cont  = r_cont;
    w_acc   = r_acc;
    w_frame = r_frame;
    w_fv    = 1'b0;
    w_samp  = r_acc;
    w_samp[r_sel] = z;
    case (r_state)
      IDLE: begin
        if (start && (mask != 4'd0)) begin
          w_mask  = mask;
          w_cont  = cont && !stop;
          w_acc   = 4'd0;
          w_sel   = f_lowest(mask);
          w_cnt   = '0;
          w_state = SCAN;
        end
      end
      SCAN: begin
        if (stop) w_cont = 1'b0;
        if (r_cnt == CW'(DWELL - 1)) begin
          w_cnt = '0;
          if (f_is_last(r_mask, r_sel)) begin
            w_frame = w_samp;
            w_fv    = 1'b1;
            if (r_cont && !stop) begin
              w_acc = 4'd0;
              w_sel = f_lowest(r_mask);
            end else begin
              w_acc   = w_samp;
              w_state = IDLE;
            end
          end else begin
            w_acc = w_samp;
            w_sel = f_next(r_mask, r_sel);
          end
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_sel   <= 2'd0;
      r_cnt   <= '0;
      r_mask  <= 4'd0;
      r_cont  <= 1'b0;
      r_acc   <= 4'd0;
      r_frame <= 4'd0;
      r_fv    <= 1'b0;
    end else begin
      r_state <= w_state;
      r_sel   <= w_sel;
      r_cnt   <= w_cnt;
      r_mask  <= w_mask;
      r_cont  <= w_cont;
      r_acc   <= w_acc;
      r_frame <= w_frame;
      r_fv    <= w_fv;
    end
  end

  assign sel         = r_sel;
  assign busy        = (r_state == SCAN);
  assign frame       = r_frame;
  assign frame_valid = r_fv;

endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// Directed bench for mux4_scan_ctrl: two instances (DWELL=2 and DWELL=1),
// each driving its own behavioural 4:1 mux.
module tb_mux4_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst, cont, stop;
  logic [3:0] mask;
  logic       start2, start1;
  logic [3:0] din2, din1;
  logic       z2, z1;
  logic [1:0] sel2, sel1;
  logic       busy2, busy1, fv2, fv1;
  logic [3:0] frame2, frame1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign z2 = din2[sel2];
  assign z1 = din1[sel1];

  mux4_scan_ctrl #(.DWELL(2), .CW(8)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .cont(cont), .stop(stop),
    .mask(mask), .z(z2), .sel(sel2), .busy(busy2), .frame(frame2),
    .frame_valid(fv2)
  );

  mux4_scan_ctrl #(.DWELL(1), .CW(8)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .cont(cont), .stop(stop),
    .mask(mask), .z(z1), .sel(sel1), .busy(busy1), .frame(frame1),
    .frame_valid(fv1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cont = 1'b0; stop = 1'b0; mask = 4'h0;
    start2 = 1'b0; start1 = 1'b0; din2 = 4'h0; din1 = 4'h0;
    tick(); tick();
    rst = 1'b0;
    check("rst_sel", sel2, 0);
    check("rst_busy", busy2, 0);
    check("rst_frame", frame2, 0);
    check("rst_fv", fv2, 0);

    // Full single scan, DWELL=2
    din2 = 4'b1010; mask = 4'hF; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int e = 0; e < 8; e++) begin
      check($sformatf("full_sel_e%0d", e), sel2, e / 2);
      check($sformatf("full_fv_e%0d", e), fv2, 0);
      check($sformatf("full_busy_e%0d", e), busy2, 1);
      tick();
    end
    check("full_fv", fv2, 1);
    check("full_frame", frame2, 4'b1010);
    check("full_busy_fall", busy2, 0);
    tick();
    check("full_fv_drop", fv2, 0);
    check("full_frame_hold", frame2, 4'b1010);

    // Reset during an active scan
    din2 = 4'b0101; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    tick(); tick(); tick();
    check("pre_rst_busy", busy2, 1);
    rst = 1'b1;
    tick();
    check("mid_rst_sel", sel2, 0);
    check("mid_rst_busy", busy2, 0);
    check("mid_rst_frame", frame2, 0);
    check("mid_rst_fv", fv2, 0);
    tick();
    rst = 1'b0;
    for (int e = 0; e < 4; e++) tick();
    check("post_rst_idle", busy2, 0);
    check("post_rst_fv", fv2, 0);

    // Masked channels
    din2 = 4'b1111; mask = 4'b0101; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    check("msk_sel_e0", sel2, 0);
    tick();
    check("msk_sel_e1", sel2, 0);
    tick();
    check("msk_sel_e2", sel2, 2);
    tick();
    check("msk_sel_e3", sel2, 2);
    check("msk_fv_e3", fv2, 0);
    tick();
    check("msk_fv", fv2, 1);
    check("msk_frame", frame2, 4'b0101);
    check("msk_busy", busy2, 0);

    // mask==0 start is ignored
    mask = 4'h0; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    check("zmask_busy", busy2, 0);
    tick();
    check("zmask_busy2", busy2, 0);

    // Continuous mode with stop in the third frame
    din2 = 4'h3; mask = 4'hF; cont = 1'b1; start2 = 1'b1;
    tick();
    start2 = 1'b0; cont = 1'b0;
    for (int e = 1; e < 8; e++) tick();
    check("cont_fv_e7", fv2, 0);
    tick();
    check("cont_fv1", fv2, 1);
    check("cont_frame1", frame2, 4'h3);
    check("cont_busy1", busy2, 1);
    check("cont_sel_wrap", sel2, 0);
    din2 = 4'hC;
    for (int e = 9; e < 16; e++) begin
      tick();
      check($sformatf("cont_gap_fv_e%0d", e), fv2, 0);
      check($sformatf("cont_gap_busy_e%0d", e), busy2, 1);
    end
    tick();
    check("cont_fv2", fv2, 1);
    check("cont_frame2", frame2, 4'hC);
    check("cont_busy2", busy2, 1);
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    for (int e = 19; e < 24; e++) tick();
    check("stop_busy_e23", busy2, 1);
    tick();
    check("stop_fv", fv2, 1);
    check("stop_frame", frame2, 4'hC);
    check("stop_busy", busy2, 0);
    tick();
    check("stop_idle", busy2, 0);

    // DWELL=1 corner
    din1 = 4'b0110; mask = 4'hF; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int e = 0; e < 4; e++) begin
      check($sformatf("d1_sel_e%0d", e), sel1, e);
      check($sformatf("d1_fv_e%0d", e), fv1, 0);
      tick();
    end
    check("d1_fv", fv1, 1);
    check("d1_frame", frame1, 4'b0110);
    check("d1_busy", busy1, 0);

    // start, mask and cont changes during SCAN are ignored
    din2 = 4'b1111; mask = 4'b1001; start2 = 1'b1;
    tick();
    mask = 4'hF; cont = 1'b1;
    check("ign_sel_e0", sel2, 0);
    tick();
    start2 = 1'b0;
    check("ign_sel_e1", sel2, 0);
    tick();
    check("ign_sel_e2", sel2, 3);
    tick();
    check("ign_sel_e3", sel2, 3);
    tick();
    check("ign_fv", fv2, 1);
    check("ign_frame", frame2, 4'b1001);
    check("ign_busy", busy2, 0);
    cont = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mux4_scan_ctrl.md
Name: mux4_scan_ctrl

Overview:
Sequencer that sits directly upstream of the 4-to-1 mux. It drives the mux select, dwells on each enabled channel, samples the mux output and assembles the four sampled bits into a frame. It runs in single-shot or continuous mode and reports each completed frame with a one-cycle valid pulse.

Parameters:
DWELL, 2, cycles `sel` is held per channel before sampling; legal range 1..255.
CW, 8, dwell counter width; must satisfy 2**CW > DWELL.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  begin scan; acted on only in IDLE.
cont  input  1  continuous mode; captured with start.
stop  input  1  clears continuous mode; the current frame still completes.
mask  input  4  channel enable, bit i = channel i; captured with start.
z  input  1  mux output, combinational from `sel`.
sel  output  2  mux select.
busy  output  1  high in the SCAN state.
frame  output  4  last completed frame; bit i = sample of channel i, 0 if masked.
frame_valid  output  1  one-cycle pulse when `frame` updates.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, sel=0, busy=0, frame=0, frame_valid=0, dwell counter=0, captured mask=0, captured cont=0, accumulator=0. Reset overrides everything, including a scan in progress.
- States: IDLE, SCAN. Registered outputs only; `frame_valid` defaults to 0 every cycle unless set as below.
- IDLE:
  - start=1 and mask!=0: capture mask and cont, clear the accumulator, set sel to the lowest enabled channel, counter=0, go to SCAN.
  - start=1 and mask==0: ignored; stay in IDLE.
- SCAN, per channel: `sel` is held for DWELL cycles. The counter counts 0..DWELL-1. At the edge where counter==DWELL-1:
  - Write z into accumulator[sel].
  - Reset the counter to 0.
  - Advance sel to the next enabled channel above the current one. Masked channels take zero cycles and their bit stays 0.
- Frame end: at the sampling edge of the highest enabled channel, write frame <= accumulator with the just-sampled bit merged in, and set frame_valid=1 for the following cycle. Then:
  - If captured cont=1: clear the accumulator, set sel to the lowest enabled channel, stay in SCAN with no gap cycle.
  - Otherwise: go to IDLE, busy=0, sel holds its last value.
- Latency: with N enabled channels, frame_valid is high exactly N*DWELL cycles after the start-accept edge. Example: start sampled at edge 0, mask=4'hF, DWELL=2 gives samples at edges 2, 4, 6, 8 and frame_valid high in the cycle after edge 8.
- stop=1 at any edge in SCAN clears captured cont; the scan finishes the current frame and returns to IDLE. stop and start together in IDLE: start wins, cont is captured as 0.
- start while in SCAN is ignored. mask and cont changes mid-scan have no effect until the next accepted start.
- `frame` holds its value between pulses and is never partially updated.

Test Plan:
- Reset and idle: assert rst for 2 cycles during an active scan. Require sel=0, busy=0, frame=0, frame_valid=0 on the next cycle, and the block stays in IDLE with start=0.
- Full single scan: DWELL=2, mask=F, cont=0, mux din=4'b1010, one-cycle start. Require sel sequence 0,0,1,1,2,2,3,3; frame=4'b1010; frame_valid pulsing exactly 8 cycles after the start edge; busy falling in the same cycle.
- Masked channels: mask=4'b0101, din=4'b1111. Require only sel 0 and 2 visited, frame=4'b0101, frame_valid 4 cycles after start. mask=0 with start: require busy stays 0.
- Continuous mode: cont=1, mask=F. Change din from 4'h3 to 4'hC between frames. Require back-to-back frame_valid pulses 8 cycles apart with frames 3 then C, and no idle gap. Pulse stop mid-frame: require that frame completes, then busy=0.
- DWELL=1 corner: mask=F, din=4'b0110. Require sel to change every cycle (0,1,2,3), frame=4'b0110, frame_valid 4 cycles after start.
- Ignored inputs: start and a mask change during SCAN. Require an unchanged sel sequence and a frame consistent with the originally captured mask.
